memory_arbiter: RTL and testbench

Single-port RAM arbiter between the instruction cache and data cache of one core. It accepts miss fills from the icache (read-only) and fills/write-backs from the dcache. It grants one requester at a time to the RAM through a registered grant state machine, and returns per-requester wait/load signals. It sits directly below the icache/dcache pair and directly above the RAM model.

---
 rtl/memory_arbiter.sv | 174 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache fills and dcache fills/write-backs.
// Optional ARB_ROUND_ROBIN_EN alternates priority on contention; default is data priority.
module memory_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              ramerr
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] IGNT = 2'd1;
   localparam logic [1:0] DGNT = 2'd2;

   localparam logic [1:0] RAM_ACCESS = 2'b10;
   localparam logic [1:0] RAM_ERROR  = 2'b11;

   logic [1:0] state_q, state_d;
   logic       ramerr_q, ramerr_d;
   logic       d_req_s;
   logic       access_s;

   assign d_req_s  = dREN | dWEN;
   assign access_s = (ramstate == RAM_ACCESS);

`ifdef ARB_ROUND_ROBIN_EN
   // prio_q: 0 favours the icache on contention (reset), 1 favours the dcache.
   logic prio_q, prio_d;

   // Priority flips toward the other requester on each completion.
   always_comb begin
      prio_d = prio_q;
      if (state_q == DGNT && d_req_s && access_s) begin
         prio_d = 1'b0;
      end else if (state_q == IGNT && iREN && access_s) begin
         prio_d = 1'b1;
      end else begin
         prio_d = prio_q;
      end
   end

   // Round-robin priority register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end
`endif

   // Grant next-state: completion and withdrawal both return to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
            if (d_req_s && iREN) begin
               state_d = prio_q ? DGNT : IGNT;
            end else if (d_req_s) begin
               state_d = DGNT;
            end else if (iREN) begin
               state_d = IGNT;
            end else begin
               state_d = IDLE;
            end
`else
            if (d_req_s) begin
               state_d = DGNT;
            end else if (iREN) begin
               state_d = IGNT;
            end else begin
               state_d = IDLE;
            end
`endif
         end
         DGNT: begin
            if (!d_req_s || access_s) begin
               state_d = IDLE;
            end else begin
               state_d = DGNT;
            end
         end
         IGNT: begin
            if (!iREN || access_s) begin
               state_d = IDLE;
            end else begin
               state_d = IGNT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // An ERROR seen while any grant is held makes ramerr sticky until reset.
   always_comb begin
      if (state_q != IDLE && ramstate == RAM_ERROR) begin
         ramerr_d = 1'b1;
      end else begin
         ramerr_d = ramerr_q;
      end
   end

   // State and sticky error registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         ramerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ramerr_q <= ramerr_d;
      end
   end

   // Combinational RAM muxes and per-requester wait/load returns.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = {ADDR_W{1'b0}};
      ramstore = {DATA_W{1'b0}};
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = {DATA_W{1'b0}};
      dload    = {DATA_W{1'b0}};
      case (state_q)
         DGNT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (d_req_s && access_s) begin
               dwait = 1'b0;
               dload = ramload;
            end else begin
               dwait = 1'b1;
            end
         end
         IGNT: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            if (iREN && access_s) begin
               iwait = 1'b0;
               iload = ramload;
            end else begin
               iwait = 1'b1;
            end
         end
         default: begin
            ramREN = 1'b0;
            ramWEN = 1'b0;
         end
      endcase
   end

   assign ramerr = ramerr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (default build: data priority) with a load scoreboard.
module tb_memory_arbiter;
   logic        CLK;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        ramerr;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;

   localparam logic [1:0] FREE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] ACCESS = 2'b10;
   localparam logic [1:0] ERROR  = 2'b11;

   memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .ramerr(ramerr)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_exp(output logic [31:0] v);
      if (exp_q.size() > 0) begin
         v = exp_q.pop_front();
      end else begin
         v = 32'hxxxx_xxxx;
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      ramstate = FREE; ramload = 32'h0;
   endtask

   initial begin
      RST = 1'b1;
      iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
      idle_inputs();
      #2;
      chk("rst_iwait", {31'b0, iwait}, 32'd1);
      chk("rst_dwait", {31'b0, dwait}, 32'd1);
      chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
      chk("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
      chk("rst_ramaddr", ramaddr, 32'h0);
      chk("rst_ramstore", ramstore, 32'h0);
      chk("rst_loads", iload | dload, 32'h0);
      chk("rst_ramerr", {31'b0, ramerr}, 32'd0);
      step();
      RST = 1'b0;

      // Icache-only read, ACCESS on the 3rd granted cycle.
      step();
      iREN = 1'b1; iaddr = 32'h0000_0040; exp_q.push_back(32'hDEAD_BEEF);
      #2 chk("i_idle_noREN", {31'b0, ramREN}, 32'd0);
      step(); ramstate = BUSY;
      #2 chk("i_g1_ramREN", {31'b0, ramREN}, 32'd1);
      chk("i_g1_addr", ramaddr, 32'h40);
      chk("i_g1_iwait", {31'b0, iwait}, 32'd1);
      step();
      #2 chk("i_g2_addr", ramaddr, 32'h40);
      chk("i_g2_iwait", {31'b0, iwait}, 32'd1);
      step(); ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
      #2 pop_exp(exp_v);
      chk("i_g3_iwait", {31'b0, iwait}, 32'd0);
      chk("i_g3_iload", iload, exp_v);
      chk("i_g3_ramREN", {31'b0, ramREN}, 32'd1);
      step(); idle_inputs();
      #2 chk("i_done_iwait", {31'b0, iwait}, 32'd1);
      chk("i_done_ramREN", {31'b0, ramREN}, 32'd0);

      // Dcache write with dREN also high: write wins, immediate ACCESS.
      step();
      dWEN = 1'b1; dREN = 1'b1; daddr = 32'h100; dstore = 32'h1234_5678;
      exp_q.push_back(32'hCAFE_F00D);
      step(); ramstate = ACCESS; ramload = 32'hCAFE_F00D;
      #2 pop_exp(exp_v);
      chk("d_ramWEN", {31'b0, ramWEN}, 32'd1);
      chk("d_ramREN", {31'b0, ramREN}, 32'd0);
      chk("d_ramstore", ramstore, 32'h1234_5678);
      chk("d_ramaddr", ramaddr, 32'h100);
      chk("d_dwait", {31'b0, dwait}, 32'd0);
      chk("d_dload", dload, exp_v);
      step(); idle_inputs();
      #2 chk("d_done_dwait", {31'b0, dwait}, 32'd1);

      // Contention: dcache first, bubble, then icache.
      step();
      iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200;
      exp_q.push_back(32'h1111_1111);
      exp_q.push_back(32'h2222_2222);
      step(); ramstate = ACCESS; ramload = 32'h1111_1111;
      #2 pop_exp(exp_v);
      chk("c_first_addr", ramaddr, 32'h200);
      chk("c_first_dwait", {31'b0, dwait}, 32'd0);
      chk("c_first_dload", dload, exp_v);
      chk("c_first_iwait", {31'b0, iwait}, 32'd1);
      chk("c_first_iload0", iload, 32'h0);
      step(); dREN = 1'b0; ramstate = FREE;
      #2 chk("c_bubble_ramREN", {31'b0, ramREN}, 32'd0);
      chk("c_bubble_iwait", {31'b0, iwait}, 32'd1);
      step(); ramstate = ACCESS; ramload = 32'h2222_2222;
      #2 pop_exp(exp_v);
      chk("c_second_addr", ramaddr, 32'h80);
      chk("c_second_iwait", {31'b0, iwait}, 32'd0);
      chk("c_second_iload", iload, exp_v);
      step(); idle_inputs();

      // Withdrawal of dREN during BUSY.
      step();
      dREN = 1'b1; daddr = 32'h300;
      step(); ramstate = BUSY;
      #2 chk("w_grant_ramREN", {31'b0, ramREN}, 32'd1);
      chk("w_grant_dwait", {31'b0, dwait}, 32'd1);
      step(); dREN = 1'b0;
      #2 chk("w_drop_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
      chk("w_drop_dwait", {31'b0, dwait}, 32'd1);
      step(); ramstate = FREE; iREN = 1'b1; iaddr = 32'h44;
      exp_q.push_back(32'h3333_3333);
      #2 chk("w_idle_ramREN", {31'b0, ramREN}, 32'd0);
      chk("w_idle_dwait", {31'b0, dwait}, 32'd1);
      step(); ramstate = ACCESS; ramload = 32'h3333_3333;
      #2 pop_exp(exp_v);
      chk("w_next_addr", ramaddr, 32'h44);
      chk("w_next_iload", iload, exp_v);
      chk("w_no_err", {31'b0, ramerr}, 32'd0);
      step(); idle_inputs();

      // ERROR for two cycles during IGNT, then ACCESS.
      step();
      iREN = 1'b1; iaddr = 32'h48; exp_q.push_back(32'h4444_4444);
      step(); ramstate = ERROR;
      #2 chk("e_1_iwait", {31'b0, iwait}, 32'd1);
      chk("e_1_ramREN", {31'b0, ramREN}, 32'd1);
      step();
      #2 chk("e_2_iwait", {31'b0, iwait}, 32'd1);
      chk("e_2_ramerr", {31'b0, ramerr}, 32'd1);
      step(); ramstate = ACCESS; ramload = 32'h4444_4444;
      #2 pop_exp(exp_v);
      chk("e_acc_iwait", {31'b0, iwait}, 32'd0);
      chk("e_acc_iload", iload, exp_v);
      step(); idle_inputs();
      #2 chk("e_sticky", {31'b0, ramerr}, 32'd1);

      // Asynchronous reset in the middle of DGNT.
      step();
      dWEN = 1'b1; daddr = 32'h500; dstore = 32'h0000_0055;
      step(); ramstate = BUSY;
      #2 chk("r_pre_ramWEN", {31'b0, ramWEN}, 32'd1);
      RST = 1'b1;
      #1 chk("r_ramWEN", {31'b0, ramWEN}, 32'd0);
      chk("r_ramaddr", ramaddr, 32'h0);
      chk("r_ramstore", ramstore, 32'h0);
      chk("r_waits", {30'b0, iwait, dwait}, 32'd3);
      chk("r_ramerr", {31'b0, ramerr}, 32'd0);
      chk("r_loads", iload | dload, 32'h0);
      idle_inputs();
      step();
      RST = 1'b0;
      step();
      #2 chk("r_after_ramWEN", {31'b0, ramWEN}, 32'd0);

      chk("sb_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
